// File: rtl/mod_mult_interleaved_if.sv
// Start/busy/done handshake bundle for the interleaved modular multiplier.
// The caller holds the master side, the multiplier holds the slave side.
interface mod_mult_interleaved_if #(
  parameter int WIDTH = 100
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] prime;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (
    output start, a_in, b_in, prime,
    input  result, busy, done
  );

  modport slave (
    input  start, a_in, b_in, prime,
    output result, busy, done
  );
endinterface

// File: rtl/mod_mult_interleaved.sv
// Sequential (a*b) mod p using MSB-first interleaved shift-add with
// conditional subtraction after each shift and after each add.
module mod_mult_interleaved #(
  parameter int WIDTH = 100,
  parameter int CNT_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_mult_interleaved_if.slave bus
);
  localparam int XW = WIDTH + 2;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] result_r;
  logic             busy_r;
  logic             done_r;

  logic [XW-1:0] p_ext_s;
  logic [XW-1:0] t_s;
  logic [XW-1:0] t_red_s;
  logic [XW-1:0] add_s;
  logic [XW-1:0] u_s;
  logic [XW-1:0] u_red_s;
  logic          unused_s;

  // One iteration: double, reduce, add the selected multiplicand, reduce.
  always_comb begin
    p_ext_s = {2'b00, p_r};
    t_s     = {1'b0, acc_r, 1'b0};
    if (t_s >= p_ext_s) begin
      t_red_s = t_s - p_ext_s;
    end else begin
      t_red_s = t_s;
    end
    if (b_r[cnt_r]) begin
      add_s = {2'b00, a_r};
    end else begin
      add_s = {XW{1'b0}};
    end
    u_s = t_red_s + add_s;
    if (u_s >= p_ext_s) begin
      u_red_s = u_s - p_ext_s;
    end else begin
      u_red_s = u_s;
    end
  end

  // With A < P the top two bits of the reduced sum are always zero.
  assign unused_s = ^u_red_s[XW-1:WIDTH];

  // Control FSM, operand latches, accumulator and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      p_r      <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      result_r <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.prime < WIDTH'(2)) begin
              // Degenerate modulus: everything reduces to zero.
              result_r <= {WIDTH{1'b0}};
              done_r   <= 1'b1;
            end else begin
              a_r     <= bus.a_in;
              b_r     <= bus.b_in;
              p_r     <= bus.prime;
              acc_r   <= {WIDTH{1'b0}};
              cnt_r   <= CNT_W'(WIDTH - 1);
              busy_r  <= 1'b1;
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc_r <= u_red_s[WIDTH-1:0];
          if (cnt_r == {CNT_W{1'b0}}) begin
            result_r <= u_red_s[WIDTH-1:0];
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.result = result_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
endmodule

// File: doc/mod_mult_interleaved.md
# mod_mult_interleaved

Sequential modular multiplier computing `result = (a_in * b_in) mod prime` for the Diffie-Hellman datapath. It uses MSB-first interleaved shift-add with per-step conditional subtraction, so no full-width product is ever formed. It is the multiply/reduce stage that `modular_exp_async` calls for every square and multiply step of the exponentiation. The start/busy/done handshake lets the exponentiator sequence it directly.

## Interface
- `WIDTH`, default 100: operand, prime and result width.
- `CNT_W`, default 7: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk`  in  1  system clock; rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a_in`  in  WIDTH  multiplicand; caller guarantees `a_in < prime`.
- `b_in`  in  WIDTH  multiplier; any value.
- `prime`  in  WIDTH  modulus.
- `result`  out  WIDTH  product mod prime; registered.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when `result` updates.

## Operation
- States: IDLE, RUN.
- **IDLE, `start`=1:**
  - Latch `a_in`, `b_in` and `prime` into internal registers A, B and P.
  - Clear accumulator R to 0.
  - Set counter to WIDTH-1 and go to RUN.
  - `busy` is 1 from the next cycle.
- **IDLE, `start`=1, P<2 (prime 0 or 1):** write `result`=0, pulse `done`, stay in IDLE. `busy` never rises.
- **RUN, one iteration per cycle for bit i = counter, from WIDTH-1 down to 0:**
  - t = 2R, as a WIDTH+2-bit value.
  - If t ≥ P, t = t − P.
  - u = t + (B[i] ? A : 0).
  - If u ≥ P, u = u − P.
  - R = u.
- **Widths:** all compares and subtracts are WIDTH+2 bits wide, so no overflow is possible. R < P holds after every iteration provided A < P.
- **Last iteration (counter = 0):**
  - Write `result` = u and set `done` = 1.
  - Clear `busy` and return to IDLE.
- `start` while in RUN is ignored. It is not queued.
- Inputs are don't-care after the start edge; only the latched copies are used.
- If A ≥ P, `result` is unspecified, but the latency and handshake are unchanged.
- **Reset (asynchronous, any state):**
  - State → IDLE.
  - `result`=0, `busy`=0, `done`=0, R=0, counter=0.
  - An operation in flight is discarded with no `done`.

## Timing
- Edge E0: `start` sampled high in IDLE.
- Edges E1..E_WIDTH: iterations for bits WIDTH-1..0.
- At E_WIDTH: `result` valid and `done`=1.
- `busy` is high from E0 to E_WIDTH, i.e. for WIDTH cycles.
- Latency from start edge to `done` = WIDTH cycles: 100 at the default width.
- `done` is high for exactly one cycle (E_WIDTH to E_WIDTH+1).
- `result` holds until the next completion or reset.
- Earliest next `start` sample is E_WIDTH+1. A `start` there is accepted even though `done` is still high in that cycle, and `done` then falls as normal.
- P<2 case: `done` at E0+1 cycle, `result`=0.
- Reset values: `result`=0, `busy`=0, `done`=0.

## Test plan
- a=5, b=5, p=23 → `done` exactly 100 cycles after start edge, `result`=2; `busy` high for 100 cycles.
- Back-to-back operations, with the second start issued in the `done` cycle:
  - a=7, b=11, p=23 → `result`=8.
  - Then a=22, b=22, p=23 → `result`=1.
- b=0, a=17, p=23 → `result`=0. Then p=2^100−3, a=b=p−1 → `result`=1; this checks the full-width carry path.
- Pulse `start` again 40 cycles into a run with different operands → ignored; original result delivered at cycle 100, a single `done`.
- Assert `rst` 50 cycles into a run → `busy`, `done` and `result` go to 0 immediately; no `done` follows. A fresh start then completes normally.
- p=1, a=0, b=9 → `done` one cycle after start, `result`=0, `busy` never high.
